mod_counter: RTL and testbench

//   Parametrised up/down counter. Features: programmable modulus, wrap or

---
 rtl/mod_counter.sv | 112 +++++++++++
 tb/tb_mod_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// mod_counter
//   Parametrised up/down counter with programmable modulus, wrap or saturate
//   behaviour at the range ends, synchronous clear and load, an enable
//   prescaler, a registered terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH     counter width in bits (>=2)
//   MAX_VAL   top of the count range; the count spans 0..MAX_VAL
//   PRESCALE  enabled cycles per count tick (>=1)
//   SATURATE  0 = wrap at the range ends, 1 = hold at the range ends
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   en    count enable, also advances the prescaler
//   clr   synchronous clear of count, prescaler and ovf (highest priority)
//   load  synchronous load of in into the count (clamped to MAX_VAL)
//   up    direction, 1 = increment, 0 = decrement (sampled on tick)
//   in    load value
//   out   current count (registered)
//   tc    terminal-count pulse, high the cycle after a boundary event
//   ovf   sticky overflow/underflow flag
module mod_counter #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL  = '1,
  parameter int               PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  logic tick;
  logic boundary;

  // A load value above the range is clamped so out never leaves 0..MAX_VAL.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Next count on a tick; at a range end either wrap or hold.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic             dir);
    logic [WIDTH-1:0] nxt;
    if (dir) begin
      if (cur == MAX_VAL) nxt = SATURATE ? cur : '0;
      else                nxt = cur + WIDTH'(1);
    end else begin
      if (cur == '0)      nxt = SATURATE ? cur : MAX_VAL;
      else                nxt = cur - WIDTH'(1);
    end
    return nxt;
  endfunction

  assign boundary = up ? (out == MAX_VAL) : (out == '0);

  generate
    if (PRESCALE > 1) begin : g_psc
      localparam int               PSC_W = $clog2(PRESCALE);
      localparam logic [PSC_W-1:0] LAST  = PSC_W'(PRESCALE - 1);

      logic [PSC_W-1:0] psc;

      assign tick = en && (psc == LAST);

      // Prescaler restarts on clr/load so the first tick after either is a
      // full PRESCALE enabled cycles away.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          psc <= '0;
        end else if (clr || load) begin
          psc <= '0;
        end else if (en) begin
          psc <= (psc == LAST) ? '0 : psc + PSC_W'(1);
        end
      end
    end else begin : g_nopsc
      assign tick = en;
    end
  endgenerate

  // Count stage: clr > load > tick, tc defaults low every other cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (clr) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= clamp_load(in);
      tc  <= 1'b0;
    end else if (tick) begin
      out <= next_count(out, up);
      tc  <= boundary;
      if (boundary) ovf <= 1'b1;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter
//   Three counters (WIDTH=4, MAX_VAL=9) share one stimulus stream:
//     [0] wrap, PRESCALE=1   [1] saturate, PRESCALE=1   [2] wrap, PRESCALE=3
//   A behavioural model tracks every instance and is compared on each
//   falling edge; directed literal expectations pin the model.
module tb_mod_counter;

  localparam int W    = 4;
  localparam int MAXV = 9;
  localparam int N    = 3;

  logic         clk;
  logic         rst, en, clr, load, up;
  logic [W-1:0] din;
  logic [W-1:0] o_out [N];
  logic         o_tc  [N];
  logic         o_ovf [N];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int PRE  [N] = '{1, 1, 3};
  bit SATM [N] = '{1'b0, 1'b1, 1'b0};
  int m_out[N];
  int m_psc[N];
  int m_tc [N];
  int m_ovf[N];

  mod_counter #(.WIDTH(W), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .up(up), .in(din),
    .out(o_out[0]), .tc(o_tc[0]), .ovf(o_ovf[0]));

  mod_counter #(.WIDTH(W), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .up(up), .in(din),
    .out(o_out[1]), .tc(o_tc[1]), .ovf(o_ovf[1]));

  mod_counter #(.WIDTH(W), .MAX_VAL(4'd9), .PRESCALE(3), .SATURATE(1'b0)) u_psc (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .up(up), .in(din),
    .out(o_out[2]), .tc(o_tc[2]), .ovf(o_ovf[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_out[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Counting is modular arithmetic over MAXV+1 values; saturation skips the
  // step when it would cross a range end.
  task automatic model_step();
    bit bnd;
    for (int i = 0; i < N; i++) begin
      if (rst || clr) begin
        m_out[i] = 0; m_psc[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
      end else if (load) begin
        m_out[i] = (int'(din) > MAXV) ? MAXV : int'(din);
        m_psc[i] = 0;
        m_tc[i]  = 0;
      end else if (en && (m_psc[i] + 1 == PRE[i])) begin
        m_psc[i] = 0;
        bnd = up ? (m_out[i] == MAXV) : (m_out[i] == 0);
        if (!(bnd && SATM[i]))
          m_out[i] = up ? (m_out[i] + 1) % (MAXV + 1) : (m_out[i] + MAXV) % (MAXV + 1);
        m_tc[i] = bnd ? 1 : 0;
        if (bnd) m_ovf[i] = 1;
      end else begin
        if (en) m_psc[i] = m_psc[i] + 1;
        m_tc[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("cmp_out%0d", i), int'(o_out[i]), m_out[i]);
        chk($sformatf("cmp_tc%0d", i),  int'(o_tc[i]),  m_tc[i]);
        chk($sformatf("cmp_ovf%0d", i), int'(o_ovf[i]), m_ovf[i]);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b1; din = '0;
    model_reset();
    #1;
    chk("rst_out", int'(o_out[0]), 0);
    chk("rst_tc",  int'(o_tc[0]),  0);
    chk("rst_ovf", int'(o_ovf[0]), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Wrap counting up through MAX_VAL.
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("wrap_out", int'(o_out[0]), (k <= 9) ? k : k - 10);
      chk("wrap_tc",  int'(o_tc[0]),  (k == 10) ? 1 : 0);
      chk("wrap_ovf", int'(o_ovf[0]), (k >= 10) ? 1 : 0);
    end

    // Prescaler: ticks every third enabled cycle, frozen while en=0.
    en = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle();
      chk("psc_out", int'(o_out[2]), k / 3);
    end
    cycle();
    chk("psc_mid", int'(o_out[2]), 3);
    en = 1'b0;
    cycle();
    chk("psc_frz1", int'(o_out[2]), 3);
    cycle();
    chk("psc_frz2", int'(o_out[2]), 3);
    en = 1'b1;
    cycle();
    chk("psc_res1", int'(o_out[2]), 3);
    cycle();
    chk("psc_res2", int'(o_out[2]), 4);

    // Saturating count down from a loaded 2.
    en = 1'b0; clr = 1'b1;
    cycle();
    clr = 1'b0; load = 1'b1; din = 4'd2;
    cycle();
    chk("sat_load", int'(o_out[1]), 2);
    load = 1'b0; up = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("sat_out", int'(o_out[1]), (k == 1) ? 1 : 0);
      chk("sat_tc",  int'(o_tc[1]),  (k >= 3) ? 1 : 0);
      chk("sat_ovf", int'(o_ovf[1]), (k >= 3) ? 1 : 0);
    end

    // Priority: clr beats load and en; load beats en.
    chk("pre_clr_ovf", int'(o_ovf[0]), 1);
    clr = 1'b1; load = 1'b1; din = 4'd7; en = 1'b1; up = 1'b1;
    cycle();
    chk("clr_out",  int'(o_out[0]), 0);
    chk("clr_ovf",  int'(o_ovf[0]), 0);
    chk("clr_ovfs", int'(o_ovf[1]), 0);
    clr = 1'b0;
    cycle();
    chk("load_out0", int'(o_out[0]), 7);
    chk("load_out1", int'(o_out[1]), 7);
    chk("load_out2", int'(o_out[2]), 7);

    // Load above range clamps, then wraps / holds on the next tick.
    din = 4'd15;
    cycle();
    chk("clamp_out", int'(o_out[0]), 9);
    load = 1'b0;
    cycle();
    chk("clamp_wrap", int'(o_out[0]), 0);
    chk("clamp_tc",   int'(o_tc[0]),  1);
    chk("clamp_sat",  int'(o_out[1]), 9);
    chk("clamp_stc",  int'(o_tc[1]),  1);

    // Asynchronous reset mid-count takes effect without a clock edge.
    load = 1'b1; din = 4'd5; en = 1'b0;
    cycle();
    load = 1'b0;
    chk("arst_pre_out", int'(o_out[0]), 5);
    chk("arst_pre_ovf", int'(o_ovf[0]), 1);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_out", int'(o_out[0]), 0);
    chk("arst_tc",  int'(o_tc[0]),  0);
    chk("arst_ovf", int'(o_ovf[0]), 0);
    chk("arst_out1", int'(o_out[1]), 0);
    en = 1'b1; up = 1'b1;
    cycle();
    chk("arst_hold", int'(o_out[0]), 0);
    rst = 1'b0;
    cycle();
    chk("post_rst", int'(o_out[0]), 1);
    up = 1'b0;
    cycle();
    chk("down_0", int'(o_out[0]), 0);
    cycle();
    chk("under_out", int'(o_out[0]), 9);
    chk("under_tc",  int'(o_tc[0]),  1);
    up = 1'b1;
    repeat (3) cycle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
